puf_majority_voter: RTL and testbench

- Sits directly downstream of the RO-PUF core and also drives its start and master_challenge inputs.
- On request, runs the PUF RUNS times with the same 8-bit challenge and accumulates a per-bit vote count over the 256-bit responses.
- Outputs a temporal-majority-voted key, a per-bit stability mask and a stable-bit count.
- Feeds key generation and authentication logic further downstream.

---
 rtl/puf_majority_voter.sv | 138 +++++++++++++
 tb/tb_puf_majority_voter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_majority_voter.sv
// rtl/puf_majority_voter.sv - temporal majority voter over repeated RO-PUF evaluations
// Runs the PUF RUNS times per request and reports a voted key, stability mask and stable-bit count.
module puf_majority_voter #(
   parameter int RESP_W  = 256,
   parameter int RUNS    = 5,
   parameter int TIMEOUT = 1048576
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic [7:0]        challenge_in,
   output logic              puf_start,
   output logic [7:0]        puf_challenge,
   input  logic [RESP_W-1:0] puf_response,
   input  logic              puf_done,
   output logic [RESP_W-1:0] key,
   output logic [RESP_W-1:0] stable_mask,
   output logic [8:0]        stable_count,
   output logic              valid,
   output logic              error,
   output logic              busy
);

   localparam int VW = $clog2(RUNS + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_WAIT, S_ACCUM, S_DECIDE, S_REPORT, S_ERR
   } state_t;

   state_t            state;
   logic [VW-1:0]     vote [RESP_W];
   logic [RESP_W-1:0] capture;
   logic [3:0]        run_cnt;
   logic [23:0]       tmo_cnt;
   logic              done_q;
   logic              rep_phase;
   logic              done_rise;

   assign done_rise = puf_done & ~done_q;

   function automatic logic [8:0] popcount(input logic [RESP_W-1:0] v);
      logic [8:0] c;
      c = '0;
      for (int i = 0; i < RESP_W; i++) c = c + 9'(v[i]);
      return c;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         key           <= '0;
         stable_mask   <= '0;
         stable_count  <= '0;
         valid         <= 1'b0;
         error         <= 1'b0;
         puf_start     <= 1'b0;
         puf_challenge <= '0;
         busy          <= 1'b0;
         capture       <= '0;
         run_cnt       <= '0;
         tmo_cnt       <= '0;
         done_q        <= 1'b0;
         rep_phase     <= 1'b0;
         for (int i = 0; i < RESP_W; i++) vote[i] <= '0;
      end else begin
         done_q <= puf_done;
         unique case (state)
            S_IDLE: begin
               if (req) begin
                  puf_challenge <= challenge_in;
                  run_cnt       <= '0;
                  for (int i = 0; i < RESP_W; i++) vote[i] <= '0;
                  puf_start     <= 1'b1;
                  busy          <= 1'b1;
                  state         <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               puf_start <= 1'b0;
               tmo_cnt   <= '0;
               state     <= S_WAIT;
            end
            S_WAIT: begin
               // Only a fresh rising edge counts; a done level left over from a previous run is ignored.
               if (done_rise) begin
                  capture <= puf_response;
                  state   <= S_ACCUM;
               end else if (tmo_cnt == 24'(TIMEOUT - 1)) begin
                  error <= 1'b1;
                  state <= S_ERR;
               end else begin
                  tmo_cnt <= tmo_cnt + 24'd1;
               end
            end
            S_ACCUM: begin
               for (int i = 0; i < RESP_W; i++) vote[i] <= vote[i] + VW'(capture[i]);
               run_cnt <= run_cnt + 4'd1;
               if ({1'b0, run_cnt} + 5'd1 == 5'(RUNS)) begin
                  state <= S_DECIDE;
               end else begin
                  puf_start <= 1'b1;
                  state     <= S_LAUNCH;
               end
            end
            S_DECIDE: begin
               for (int i = 0; i < RESP_W; i++) begin
                  key[i]         <= (vote[i] >= VW'((RUNS + 1) / 2));
                  stable_mask[i] <= (vote[i] == '0) || (vote[i] == VW'(RUNS));
               end
               rep_phase <= 1'b0;
               state     <= S_REPORT;
            end
            S_REPORT: begin
               // Two cycles: count the registered mask, then hold valid alongside the new count.
               if (!rep_phase) begin
                  stable_count <= popcount(stable_mask);
                  valid        <= 1'b1;
                  rep_phase    <= 1'b1;
               end else begin
                  valid <= 1'b0;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            S_ERR: begin
               error <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_puf_majority_voter.sv
// tb/tb_puf_majority_voter.sv - self-checking bench for puf_majority_voter
// Behavioural PUF model plus a vote-sum reference model; table vectors, random vectors and corner sequences.
module tb_puf_majority_voter;

   localparam int RUNS     = 5;
   localparam int TIMEOUT  = 1000;
   localparam int W        = 256;
   localparam int M_NORMAL = 0;
   localparam int M_NEVER  = 1;
   localparam int M_STUCK  = 2;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         req = 1'b0;
   logic [7:0]   challenge_in = 8'h00;
   logic         puf_start;
   logic [7:0]   puf_challenge;
   logic [W-1:0] puf_response = '0;
   logic         puf_done = 1'b0;
   logic [W-1:0] key;
   logic [W-1:0] stable_mask;
   logic [8:0]   stable_count;
   logic         valid;
   logic         error;
   logic         busy;

   always #5 clk = ~clk;

   puf_majority_voter #(.RESP_W(W), .RUNS(RUNS), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req(req), .challenge_in(challenge_in),
      .puf_start(puf_start), .puf_challenge(puf_challenge),
      .puf_response(puf_response), .puf_done(puf_done),
      .key(key), .stable_mask(stable_mask), .stable_count(stable_count),
      .valid(valid), .error(error), .busy(busy)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // PUF model and event monitor share one process so counters have a single writer.
   int           cyc = 0, n_start = 0, n_valid = 0, n_err = 0, n_both = 0, chal_bad = 0;
   int           start_cyc = 0, err_cyc = 0, req_base = 0;
   logic [7:0]   cur_chal = 8'h00;
   int           mode = M_NORMAL, delay = 1;
   logic [W-1:0] resp_tab [RUNS];
   int           pend = 0, cnt = 0, ridx = 0;

   always @(negedge clk) begin
      cyc++;
      if (valid) n_valid++;
      if (error) begin n_err++; err_cyc = cyc; end
      if (valid && error) n_both++;
      if (reset) begin
         pend = 0;
         puf_done = 1'b0;
      end else if (puf_start) begin
         n_start++;
         start_cyc = cyc;
         if (puf_challenge !== cur_chal) chal_bad++;
         ridx = n_start - req_base - 1;
         if (ridx > RUNS - 1) ridx = RUNS - 1;
         if (ridx < 0) ridx = 0;
         if (mode != M_STUCK) puf_done = 1'b0;
         if (mode == M_NORMAL) begin pend = 1; cnt = delay; end
         else pend = 0;
      end else if (pend != 0) begin
         cnt--;
         if (cnt <= 0) begin
            pend = 0;
            puf_response = resp_tab[ridx];
            puf_done = 1'b1;
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   logic [W-1:0] exp_key, exp_mask, last_key, last_mask;
   int           exp_cnt, last_cnt;

   task automatic model();
      int s;
      exp_cnt = 0;
      for (int b = 0; b < W; b++) begin
         s = 0;
         for (int r = 0; r < RUNS; r++) s += int'(resp_tab[r][b]);
         exp_key[b]  = (2 * s > RUNS);
         exp_mask[b] = (s == 0) || (s == RUNS);
         if (exp_mask[b]) exp_cnt++;
      end
   endtask

   task automatic fill_random();
      for (int r = 0; r < RUNS; r++)
         for (int w = 0; w < W / 32; w++) resp_tab[r][w*32 +: 32] = $urandom;
   endtask

   task automatic do_req(input logic [7:0] chal, input int m, input int d, input bit dup,
                         output int dv, output int de, output int ds, output int dc,
                         output bit b_fin, output bit b_next);
      int v0, e0, s0, c0;
      bit dup_done, fin;
      dup_done = 1'b0;
      fin = 1'b0;
      v0 = n_valid; e0 = n_err; s0 = n_start; c0 = chal_bad;
      cur_chal = chal; mode = m; delay = d; req_base = n_start;
      challenge_in = chal;
      req = 1'b1;
      step();
      req = 1'b0;
      challenge_in = ~chal;
      for (int k = 0; k < RUNS * (d + 4) + TIMEOUT + 20 && !fin; k++) begin
         step();
         if (dup && !dup_done && n_start - s0 == 3) begin
            req = 1'b1;
            challenge_in = 8'h99;
            dup_done = 1'b1;
         end else begin
            req = 1'b0;
         end
         if (n_valid != v0 || n_err != e0) fin = 1'b1;
      end
      req = 1'b0;
      if (!fin) begin
         total++;
         bad++;
         $display("FAIL req_bound: no valid or error within cycle budget, chal=%h", chal);
      end
      b_fin = busy;
      step();
      b_next = busy;
      repeat (3) step();
      dv = n_valid - v0; de = n_err - e0; ds = n_start - s0; dc = chal_bad - c0;
   endtask

   task automatic check_good(input string tag, input int dv, input int de, input int ds, input int dc);
      chk({tag, "_key"},   key, exp_key);
      chk({tag, "_mask"},  stable_mask, exp_mask);
      chk({tag, "_count"}, W'(stable_count), W'(exp_cnt));
      chk({tag, "_valids"}, W'(dv), W'(1));
      chk({tag, "_errors"}, W'(de), W'(0));
      chk({tag, "_starts"}, W'(ds), W'(RUNS));
      chk({tag, "_chal_held"}, W'(dc), W'(0));
      chk({tag, "_idle"}, W'(busy), W'(0));
      last_key = exp_key; last_mask = exp_mask; last_cnt = exp_cnt;
   endtask

   typedef struct {
      logic [7:0] chal;
      logic [7:0] base;
      int         bit_a;
      logic [4:0] pat_a;
      int         bit_b;
      logic [4:0] pat_b;
      int         dly;
      int         exp_cnt;
   } vec_t;

   vec_t vt [4];

   initial begin
      int dv, de, ds, dc;
      bit bf, bn;
      logic [W-1:0] a5_all;

      vt[0] = '{8'h3C, 8'hA5, -1,  5'b00000, -1,  5'b00000, 300, 256};
      vt[1] = '{8'h5A, 8'hA5, 7,   5'b01011, 200, 5'b00010, 10,  254};
      vt[2] = '{8'h00, 8'hFF, 0,   5'b11111, 255, 5'b00000, 3,   256};
      vt[3] = '{8'hFF, 8'h00, 100, 5'b10101, 101, 5'b01010, 1,   254};
      a5_all = {32{8'hA5}};

      reset = 1'b1;
      repeat (3) step();
      chk("rst_key", key, '0);
      chk("rst_mask", stable_mask, '0);
      chk("rst_ctl", W'({stable_count, valid, error, puf_start, busy, puf_challenge}), '0);
      reset = 1'b0;
      step();

      for (int v = 0; v < 4; v++) begin
         for (int r = 0; r < RUNS; r++) begin
            resp_tab[r] = {32{vt[v].base}};
            if (vt[v].bit_a >= 0) resp_tab[r][vt[v].bit_a] = vt[v].pat_a[r];
            if (vt[v].bit_b >= 0) resp_tab[r][vt[v].bit_b] = vt[v].pat_b[r];
         end
         model();
         do_req(vt[v].chal, M_NORMAL, vt[v].dly, 1'b0, dv, de, ds, dc, bf, bn);
         check_good($sformatf("vec%0d", v), dv, de, ds, dc);
         chk($sformatf("vec%0d_tablecount", v), W'(stable_count), W'(vt[v].exp_cnt));
         if (v == 0) chk("vec0_key_a5", key, a5_all);
         if (v == 1) chk("vec1_bits", W'({key[7], key[200], stable_mask[7], stable_mask[200]}), W'(4'b1000));
      end

      for (int v = 0; v < 4; v++) begin
         fill_random();
         model();
         do_req(8'($urandom), M_NORMAL, $urandom_range(1, 40), v == 2, dv, de, ds, dc, bf, bn);
         check_good($sformatf("rnd%0d", v), dv, de, ds, dc);
      end

      // PUF never completes: error after TIMEOUT cycles in WAIT, outputs retained.
      do_req(8'h77, M_NEVER, 0, 1'b0, dv, de, ds, dc, bf, bn);
      chk("tmo_error", W'(de), W'(1));
      chk("tmo_valid", W'(dv), W'(0));
      chk("tmo_starts", W'(ds), W'(1));
      chk("tmo_latency", W'(err_cyc - start_cyc), W'(TIMEOUT + 1));
      chk("tmo_busy", W'({bf, bn}), W'(2'b10));
      chk("tmo_key_kept", key, last_key);
      chk("tmo_count_kept", W'(stable_count), W'(last_cnt));

      // Leave done high, then a run whose done never falls must time out.
      fill_random();
      model();
      do_req(8'h21, M_NORMAL, 7, 1'b0, dv, de, ds, dc, bf, bn);
      check_good("pre_stuck", dv, de, ds, dc);
      do_req(8'h22, M_STUCK, 0, 1'b0, dv, de, ds, dc, bf, bn);
      chk("stuck_error", W'(de), W'(1));
      chk("stuck_valid", W'(dv), W'(0));
      chk("stuck_mask_kept", stable_mask, last_mask);
      fill_random();
      model();
      do_req(8'h23, M_NORMAL, 5, 1'b0, dv, de, ds, dc, bf, bn);
      check_good("post_stuck", dv, de, ds, dc);

      // Reset during WAIT of run 2, then a clean request.
      fill_random();
      cur_chal = 8'h4D; mode = M_NORMAL; delay = 20; req_base = n_start;
      begin
         int s0;
         int k;
         s0 = n_start;
         challenge_in = 8'h4D;
         req = 1'b1;
         step();
         req = 1'b0;
         k = 0;
         while (n_start - s0 < 2 && k < 400) begin step(); k++; end
         chk("mid_reach_run2", W'(n_start - s0), W'(2));
      end
      repeat (4) step();
      reset = 1'b1;
      step();
      chk("mid_rst_key", key, '0);
      chk("mid_rst_mask", stable_mask, '0);
      chk("mid_rst_ctl", W'({stable_count, valid, error, puf_start, busy, puf_challenge}), '0);
      reset = 1'b0;
      repeat (30) step();
      fill_random();
      model();
      do_req(8'h4E, M_NORMAL, 9, 1'b0, dv, de, ds, dc, bf, bn);
      check_good("after_rst", dv, de, ds, dc);

      chk("never_valid_and_error", W'(n_both), W'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
